// File: rtl/fb_write_scheduler_pkg.sv
// rtl/fb_write_scheduler_pkg.sv - shared framebuffer widths, scheduler states and default clear color
//   Shared by the pixel stages, the framebuffer and fb_write_scheduler.
//   FB_ADDR_W / FB_COLOR_W : framebuffer address and RGB565 data widths
//   FB_CNT_W               : clear sweep counter width (one bit wider than the address)
//   state_t                : scheduler FSM states
//   CLEAR_COLOR_DEFAULT    : color written by the clear sweep unless overridden
package fb_pkg;

  localparam int FB_ADDR_W  = 16;
  localparam int FB_COLOR_W = 16;
  localparam int FB_CNT_W   = 17;

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic [FB_COLOR_W-1:0] CLEAR_COLOR_DEFAULT = 16'h0000;

endpackage

// File: rtl/fb_write_scheduler_if.sv
// rtl/fb_write_scheduler_if.sv - requester/clear/write-port bundle for fb_write_scheduler
//   req_valid_in / req_addr_in / req_color_in : per-requester pixel offer
//   req_ready_out                             : one-hot (or zero) grant back to requesters
//   clear_start_in                            : one-cycle pulse starting a clear sweep
//   clear_busy_out / clear_done_out           : sweep status and final-write pulse
//   we_out / waddr_out / wdata_out            : registered framebuffer write port
//   master = pixel stages + framebuffer side, slave = the scheduler
interface fb_write_scheduler_if
  import fb_pkg::*;
#(
  parameter int NUM_REQ = 2
) ();

  logic [NUM_REQ-1:0]                  req_valid_in;
  logic [NUM_REQ-1:0][FB_ADDR_W-1:0]   req_addr_in;
  logic [NUM_REQ-1:0][FB_COLOR_W-1:0]  req_color_in;
  logic [NUM_REQ-1:0]                  req_ready_out;
  logic                                clear_start_in;
  logic                                clear_busy_out;
  logic                                clear_done_out;
  logic                                we_out;
  logic [FB_ADDR_W-1:0]                waddr_out;
  logic [FB_COLOR_W-1:0]               wdata_out;

  modport master (
    output req_valid_in, req_addr_in, req_color_in, clear_start_in,
    input  req_ready_out, clear_busy_out, clear_done_out, we_out, waddr_out, wdata_out
  );

  modport slave (
    input  req_valid_in, req_addr_in, req_color_in, clear_start_in,
    output req_ready_out, clear_busy_out, clear_done_out, we_out, waddr_out, wdata_out
  );

endinterface

// File: rtl/fb_write_scheduler_rr_arbiter.sv
// rtl/fb_write_scheduler_rr_arbiter.sv - combinational round-robin pick
//   req_in    : request vector
//   ptr_in    : highest-priority index this cycle
//   grant_out : one-hot grant of the first request at or after ptr_in (wrapping), or zero
//   idx_out   : index of the granted request (0 when nothing is granted)
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_in,
  input  logic [PTR_W-1:0]   ptr_in,
  output logic [NUM_REQ-1:0] grant_out,
  output logic [PTR_W-1:0]   idx_out
);

  logic found;
  int   j;

  always_comb begin
    grant_out = '0;
    idx_out   = '0;
    found     = 1'b0;
    j         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // Scan ptr, ptr+1, ... wrapping once around the vector.
      j = int'(ptr_in) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req_in[j]) begin
        found        = 1'b1;
        grant_out[j] = 1'b1;
        idx_out      = PTR_W'(j);
      end
    end
  end

endmodule

// File: rtl/fb_write_scheduler.sv
// rtl/fb_write_scheduler.sv - shares the framebuffer write port between pixel requesters and a clear sweep
//   clk_in : system clock, everything on posedge
//   rst_in : synchronous active-high reset
//   bus    : fb_write_scheduler_if.slave (requests, grants, clear control, registered write port)
//   Params : NUM_REQ requesters (1..8), FB_DEPTH words (<= 65535), CLEAR_COLOR sweep data
module fb_write_scheduler
  import fb_pkg::*;
#(
  parameter int                    NUM_REQ     = 2,
  parameter int                    FB_DEPTH    = 57600,
  parameter logic [FB_COLOR_W-1:0] CLEAR_COLOR = CLEAR_COLOR_DEFAULT
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  fb_write_scheduler_if.slave  bus
);

  localparam int                  PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [FB_CNT_W-1:0] DEPTH_C  = FB_CNT_W'(FB_DEPTH);
  localparam logic [FB_CNT_W-1:0] LAST_C   = FB_CNT_W'(FB_DEPTH - 1);
  localparam logic [PTR_W-1:0]    LAST_IDX = PTR_W'(NUM_REQ - 1);

  state_t                  state;
  logic [PTR_W-1:0]        rr_ptr;
  logic [FB_CNT_W-1:0]     clr_cnt;
  logic                    we_q;
  logic [FB_ADDR_W-1:0]    waddr_q;
  logic [FB_COLOR_W-1:0]   wdata_q;
  logic                    busy_q;
  logic                    done_q;

  logic [NUM_REQ-1:0]      grant;
  logic [PTR_W-1:0]        grant_idx;
  logic [NUM_REQ-1:0]      ready;
  logic                    accept;
  logic [FB_ADDR_W-1:0]    sel_addr;
  logic [FB_COLOR_W-1:0]   sel_color;
  logic                    addr_ok;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req_in    (bus.req_valid_in),
    .ptr_in    (rr_ptr),
    .grant_out (grant),
    .idx_out   (grant_idx)
  );

  // A clear request wins over pixels in the cycle it arrives.
  always_comb begin
    ready = '0;
    if (state == ARB && !bus.clear_start_in) ready = grant;
  end

  assign accept    = |ready;
  assign sel_addr  = bus.req_addr_in[grant_idx];
  assign sel_color = bus.req_color_in[grant_idx];
  assign addr_ok   = {1'b0, sel_addr} < DEPTH_C;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state   <= ARB;
      rr_ptr  <= '0;
      clr_cnt <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state)
        ARB: begin
          if (bus.clear_start_in) begin
            // First sweep write goes out on the very next cycle.
            state   <= CLEAR;
            clr_cnt <= FB_CNT_W'(1);
            we_q    <= 1'b1;
            waddr_q <= '0;
            wdata_q <= CLEAR_COLOR;
            busy_q  <= 1'b1;
            done_q  <= (LAST_C == '0);
          end else if (accept) begin
            rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + PTR_W'(1);
            we_q   <= addr_ok;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            // Out-of-range pixels are consumed but leave the port untouched.
            if (addr_ok) begin
              waddr_q <= sel_addr;
              wdata_q <= sel_color;
            end
          end else begin
            we_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
          end
        end
        CLEAR: begin
          if (clr_cnt == DEPTH_C) begin
            // Tail cycle: the last write is on the port now, so requesters
            // stay blocked one more cycle and arbitration resumes after it.
            state  <= ARB;
            we_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + FB_CNT_W'(1);
            we_q    <= 1'b1;
            waddr_q <= clr_cnt[FB_ADDR_W-1:0];
            wdata_q <= CLEAR_COLOR;
            busy_q  <= 1'b1;
            done_q  <= (clr_cnt == LAST_C);
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  assign bus.req_ready_out  = ready;
  assign bus.we_out         = we_q;
  assign bus.waddr_out      = waddr_q;
  assign bus.wdata_out      = wdata_q;
  assign bus.clear_busy_out = busy_q;
  assign bus.clear_done_out = done_q;

endmodule

// File: tb/tb_fb_write_scheduler.sv
// tb/tb_fb_write_scheduler.sv - directed self-checking bench for fb_write_scheduler
module tb_fb_write_scheduler;
  import fb_pkg::*;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic rst_a;
  logic rst_c;

  fb_write_scheduler_if #(.NUM_REQ(2)) bus_a ();
  fb_write_scheduler_if #(.NUM_REQ(2)) bus_c ();

  fb_write_scheduler #(.NUM_REQ(2)) dut_a (
    .clk_in (clk_in),
    .rst_in (rst_a),
    .bus    (bus_a)
  );

  fb_write_scheduler #(.NUM_REQ(2), .FB_DEPTH(16), .CLEAR_COLOR(16'h0000)) dut_c (
    .clk_in (clk_in),
    .rst_in (rst_c),
    .bus    (bus_c)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    bus_a.req_valid_in   = '0;
    bus_a.req_addr_in    = '0;
    bus_a.req_color_in   = '0;
    bus_a.clear_start_in = 1'b0;
    bus_c.req_valid_in   = '0;
    bus_c.req_addr_in    = '0;
    bus_c.req_color_in   = '0;
    bus_c.clear_start_in = 1'b0;
  endtask

  task automatic reset_a();
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
  endtask

  task automatic reset_c();
    rst_c = 1'b1;
    step();
    rst_c = 1'b0;
  endtask

  task automatic test_reset();
    rst_a = 1'b1;
    rst_c = 1'b1;
    idle_inputs();
    step();
    step();
    n_cmp++; if (bus_a.req_ready_out !== 2'b00) begin n_bad++; $display("FAIL reset_ready: got %b want 00", bus_a.req_ready_out); end
    n_cmp++; if (bus_a.we_out !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b want 0", bus_a.we_out); end
    n_cmp++; if (bus_a.waddr_out !== 16'h0000) begin n_bad++; $display("FAIL reset_waddr: got %h want 0000", bus_a.waddr_out); end
    n_cmp++; if (bus_a.wdata_out !== 16'h0000) begin n_bad++; $display("FAIL reset_wdata: got %h want 0000", bus_a.wdata_out); end
    n_cmp++; if (bus_a.clear_busy_out !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus_a.clear_busy_out); end
    n_cmp++; if (bus_a.clear_done_out !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", bus_a.clear_done_out); end
    n_cmp++; if (bus_c.we_out !== 1'b0) begin n_bad++; $display("FAIL reset_c_we: got %b want 0", bus_c.we_out); end
    rst_a = 1'b0;
    rst_c = 1'b0;
    step();
  endtask

  task automatic test_single();
    bus_a.req_valid_in    = 2'b01;
    bus_a.req_addr_in[0]  = 16'h0010;
    bus_a.req_color_in[0] = 16'h001F;
    #1;
    n_cmp++; if (bus_a.req_ready_out !== 2'b01) begin n_bad++; $display("FAIL single_ready: got %b want 01", bus_a.req_ready_out); end
    step();
    bus_a.req_valid_in = 2'b00;
    n_cmp++; if (bus_a.we_out !== 1'b1) begin n_bad++; $display("FAIL single_we: got %b want 1", bus_a.we_out); end
    n_cmp++; if (bus_a.waddr_out !== 16'h0010) begin n_bad++; $display("FAIL single_waddr: got %h want 0010", bus_a.waddr_out); end
    n_cmp++; if (bus_a.wdata_out !== 16'h001F) begin n_bad++; $display("FAIL single_wdata: got %h want 001f", bus_a.wdata_out); end
    step();
    n_cmp++; if (bus_a.we_out !== 1'b0) begin n_bad++; $display("FAIL single_idle_we: got %b want 0", bus_a.we_out); end
    n_cmp++; if (bus_a.waddr_out !== 16'h0010) begin n_bad++; $display("FAIL single_hold_waddr: got %h want 0010", bus_a.waddr_out); end
  endtask

  task automatic test_back_to_back();
    int n0;
    int n1;
    int g;
    logic [15:0] exp_addr;
    logic [15:0] exp_color;
    logic [1:0]  exp_ready;
    n0 = 0;
    n1 = 0;
    exp_addr  = '0;
    exp_color = '0;
    reset_a();
    bus_a.req_valid_in = 2'b11;
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) begin
        n_cmp++; if (bus_a.we_out !== 1'b1) begin n_bad++; $display("FAIL b2b_we[%0d]: got %b want 1", c - 1, bus_a.we_out); end
        n_cmp++; if (bus_a.waddr_out !== exp_addr) begin n_bad++; $display("FAIL b2b_waddr[%0d]: got %h want %h", c - 1, bus_a.waddr_out, exp_addr); end
        n_cmp++; if (bus_a.wdata_out !== exp_color) begin n_bad++; $display("FAIL b2b_wdata[%0d]: got %h want %h", c - 1, bus_a.wdata_out, exp_color); end
      end
      if (c < 6) begin
        bus_a.req_addr_in[0]  = 16'(16'h0200 + n0);
        bus_a.req_color_in[0] = 16'(16'hF800 + n0);
        bus_a.req_addr_in[1]  = 16'(16'h0300 + n1);
        bus_a.req_color_in[1] = 16'(16'h07E0 + n1);
        #1;
        g = c % 2;
        exp_ready = (g == 1) ? 2'b10 : 2'b01;
        n_cmp++; if (bus_a.req_ready_out !== exp_ready) begin n_bad++; $display("FAIL b2b_ready[%0d]: got %b want %b", c, bus_a.req_ready_out, exp_ready); end
        if (g == 1) begin
          exp_addr  = 16'(16'h0300 + n1);
          exp_color = 16'(16'h07E0 + n1);
          n1++;
        end else begin
          exp_addr  = 16'(16'h0200 + n0);
          exp_color = 16'(16'hF800 + n0);
          n0++;
        end
        step();
      end
    end
    bus_a.req_valid_in = 2'b00;
  endtask

  task automatic test_drop();
    bus_a.req_valid_in    = 2'b10;
    bus_a.req_addr_in[1]  = 16'd60000;
    bus_a.req_color_in[1] = 16'h1234;
    #1;
    n_cmp++; if (bus_a.req_ready_out !== 2'b10) begin n_bad++; $display("FAIL drop_ready: got %b want 10", bus_a.req_ready_out); end
    step();
    bus_a.req_valid_in = 2'b00;
    n_cmp++; if (bus_a.we_out !== 1'b0) begin n_bad++; $display("FAIL drop_we: got %b want 0", bus_a.we_out); end
    n_cmp++; if (bus_a.waddr_out !== 16'h0302) begin n_bad++; $display("FAIL drop_hold_waddr: got %h want 0302", bus_a.waddr_out); end
    n_cmp++; if (bus_a.wdata_out !== 16'h07E2) begin n_bad++; $display("FAIL drop_hold_wdata: got %h want 07e2", bus_a.wdata_out); end
    bus_a.req_valid_in    = 2'b01;
    bus_a.req_addr_in[0]  = 16'd57599;
    bus_a.req_color_in[0] = 16'h5555;
    #1;
    n_cmp++; if (bus_a.req_ready_out !== 2'b01) begin n_bad++; $display("FAIL edge_ready: got %b want 01", bus_a.req_ready_out); end
    step();
    bus_a.req_addr_in[0]  = 16'd57600;
    bus_a.req_color_in[0] = 16'hAAAA;
    n_cmp++; if (bus_a.we_out !== 1'b1) begin n_bad++; $display("FAIL edge_last_we: got %b want 1", bus_a.we_out); end
    n_cmp++; if (bus_a.waddr_out !== 16'd57599) begin n_bad++; $display("FAIL edge_last_waddr: got %0d want 57599", bus_a.waddr_out); end
    step();
    bus_a.req_valid_in = 2'b00;
    n_cmp++; if (bus_a.we_out !== 1'b0) begin n_bad++; $display("FAIL edge_depth_we: got %b want 0", bus_a.we_out); end
    n_cmp++; if (bus_a.wdata_out !== 16'h5555) begin n_bad++; $display("FAIL edge_depth_wdata: got %h want 5555", bus_a.wdata_out); end
  endtask

  task automatic test_clear();
    reset_c();
    bus_c.req_valid_in    = 2'b01;
    bus_c.req_addr_in[0]  = 16'd5;
    bus_c.req_color_in[0] = 16'hABCD;
    bus_c.clear_start_in  = 1'b1;
    #1;
    n_cmp++; if (bus_c.req_ready_out !== 2'b00) begin n_bad++; $display("FAIL clr_start_ready: got %b want 00", bus_c.req_ready_out); end
    step();
    bus_c.clear_start_in = 1'b0;
    for (int k = 0; k < 16; k++) begin
      bus_c.clear_start_in = (k == 5);
      #1;
      n_cmp++; if (bus_c.we_out !== 1'b1) begin n_bad++; $display("FAIL clr_we[%0d]: got %b want 1", k, bus_c.we_out); end
      n_cmp++; if (bus_c.waddr_out !== 16'(k)) begin n_bad++; $display("FAIL clr_waddr[%0d]: got %0d want %0d", k, bus_c.waddr_out, k); end
      n_cmp++; if (bus_c.wdata_out !== 16'h0000) begin n_bad++; $display("FAIL clr_wdata[%0d]: got %h want 0000", k, bus_c.wdata_out); end
      n_cmp++; if (bus_c.clear_busy_out !== 1'b1) begin n_bad++; $display("FAIL clr_busy[%0d]: got %b want 1", k, bus_c.clear_busy_out); end
      n_cmp++; if (bus_c.clear_done_out !== (k == 15)) begin n_bad++; $display("FAIL clr_done[%0d]: got %b want %b", k, bus_c.clear_done_out, (k == 15)); end
      n_cmp++; if (bus_c.req_ready_out !== 2'b00) begin n_bad++; $display("FAIL clr_ready[%0d]: got %b want 00", k, bus_c.req_ready_out); end
      step();
    end
    bus_c.clear_start_in = 1'b0;
    #1;
    n_cmp++; if (bus_c.clear_busy_out !== 1'b0) begin n_bad++; $display("FAIL clr_after_busy: got %b want 0", bus_c.clear_busy_out); end
    n_cmp++; if (bus_c.clear_done_out !== 1'b0) begin n_bad++; $display("FAIL clr_after_done: got %b want 0", bus_c.clear_done_out); end
    n_cmp++; if (bus_c.we_out !== 1'b0) begin n_bad++; $display("FAIL clr_after_we: got %b want 0", bus_c.we_out); end
    n_cmp++; if (bus_c.req_ready_out !== 2'b01) begin n_bad++; $display("FAIL clr_after_ready: got %b want 01", bus_c.req_ready_out); end
    step();
    bus_c.req_valid_in = 2'b00;
    n_cmp++; if (bus_c.we_out !== 1'b1) begin n_bad++; $display("FAIL clr_pix_we: got %b want 1", bus_c.we_out); end
    n_cmp++; if (bus_c.waddr_out !== 16'd5) begin n_bad++; $display("FAIL clr_pix_waddr: got %0d want 5", bus_c.waddr_out); end
    n_cmp++; if (bus_c.wdata_out !== 16'hABCD) begin n_bad++; $display("FAIL clr_pix_wdata: got %h want abcd", bus_c.wdata_out); end
  endtask

  task automatic test_reset_mid_clear();
    int done_cnt;
    int write_cnt;
    done_cnt  = 0;
    write_cnt = 0;
    step();
    bus_c.clear_start_in = 1'b1;
    step();
    bus_c.clear_start_in = 1'b0;
    for (int k = 0; k < 8; k++) step();
    n_cmp++; if (bus_c.waddr_out !== 16'd8) begin n_bad++; $display("FAIL mid_waddr: got %0d want 8", bus_c.waddr_out); end
    rst_c = 1'b1;
    step();
    rst_c = 1'b0;
    n_cmp++; if (bus_c.we_out !== 1'b0) begin n_bad++; $display("FAIL mid_rst_we: got %b want 0", bus_c.we_out); end
    n_cmp++; if (bus_c.clear_busy_out !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy: got %b want 0", bus_c.clear_busy_out); end
    n_cmp++; if (bus_c.waddr_out !== 16'h0000) begin n_bad++; $display("FAIL mid_rst_waddr: got %h want 0000", bus_c.waddr_out); end
    for (int k = 0; k < 20; k++) begin
      if (bus_c.clear_done_out === 1'b1 || bus_c.we_out === 1'b1) done_cnt++;
      step();
    end
    n_cmp++; if (done_cnt !== 0) begin n_bad++; $display("FAIL mid_no_activity: got %0d cycles want 0", done_cnt); end
    done_cnt = 0;
    bus_c.clear_start_in = 1'b1;
    step();
    bus_c.clear_start_in = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (bus_c.we_out === 1'b1 && bus_c.waddr_out === 16'(k)) write_cnt++;
      if (bus_c.clear_done_out === 1'b1) done_cnt = done_cnt + ((k == 15) ? 1 : 100);
      step();
    end
    n_cmp++; if (write_cnt !== 16) begin n_bad++; $display("FAIL resweep_writes: got %0d want 16", write_cnt); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL resweep_done: got %0d want 1", done_cnt); end
    n_cmp++; if (bus_c.clear_busy_out !== 1'b0) begin n_bad++; $display("FAIL resweep_end_busy: got %b want 0", bus_c.clear_busy_out); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1;
    rst_c = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_back_to_back();
    test_drop();
    test_clear();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fb_write_scheduler.md
# fb_write_scheduler

Shares the single framebuffer BRAM write port between several pixel producers (per-pipeline pixel shading stages) and an internal clear engine. Requesters present address/RGB565 color with valid/ready; the block grants one per cycle round-robin and drives a registered write port. On command it sweeps the whole framebuffer with a clear color, stalling all requesters until done. It sits between the pixel shading stages and the framebuffer BRAM.

## Interface
- NUM_REQ, 2: number of pixel requesters (1..8)
- FB_DEPTH, 57600: framebuffer words; legal addresses 0..FB_DEPTH-1; FB_DEPTH ≤ 65535
- CLEAR_COLOR, 16'h0000: RGB565 value written by the clear sweep

- clk_in  input  1  system clock; everything on posedge
- rst_in  input  1  synchronous, active-high reset
- req_valid_in  input  NUM_REQ  requester i has a pixel
- req_addr_in  input  NUM_REQ×16  pixel address per requester
- req_color_in  input  NUM_REQ×16  RGB565 color per requester
- req_ready_out  output  NUM_REQ  one-hot (or zero) grant; transfer when valid&ready
- clear_start_in  input  1  single-cycle pulse: start clear sweep
- clear_busy_out  output  1  clear sweep in progress
- clear_done_out  output  1  one-cycle pulse on final clear write
- we_out  output  1  framebuffer write enable
- waddr_out  output  16  framebuffer write address
- wdata_out  output  16  framebuffer write data

## Operation
- States: ARB, CLEAR. Reset → ARB, rr pointer 0, clear counter 0.
- ARB: ready combinational; at most one bit set: first valid requester at or after rr pointer (wrapping). No valid → ready all 0.
- clear_start_in in ARB has priority: ready all 0 that cycle; no pixel accepted.
- Accept (valid&ready for i): next edge we_out=1, waddr_out=addr_i, wdata_out=color_i; rr pointer ← (i+1) mod NUM_REQ. No accept: we_out=0, pointer unchanged.
- Accepted address ≥ FB_DEPTH: consumed (handshake completes) but dropped; we_out=0.
- CLEAR: ready all 0; one write per cycle, addresses 0..FB_DEPTH-1 ascending, data CLEAR_COLOR; clear_start_in ignored; then → ARB. rr pointer preserved across clear.
- Counter 17 bits internally; no wrap possible.
- waddr_out/wdata_out hold last value when we_out=0.

## Timing
- Reset values: req_ready_out 0, we_out 0, waddr_out 0, wdata_out 0, clear_busy_out 0, clear_done_out 0.
- Pixel latency: accept in cycle T → write visible cycle T+1. Sustained throughput 1 pixel/cycle.
- clear_start_in in cycle T (state ARB): cycles T+1..T+FB_DEPTH carry we_out=1 with addresses 0..FB_DEPTH-1; clear_busy_out=1 exactly those cycles; clear_done_out=1 in cycle T+FB_DEPTH only; ready can assert again from T+FB_DEPTH+1.
- rst_in mid-clear: sweep aborted; next cycle all outputs at reset values, state ARB, no done pulse.
- Requesters must hold addr/color stable while valid and not ready.

## Structure
- Package fb_pkg: FB_ADDR_W=16, FB_COLOR_W=16, state enum {ARB, CLEAR}, default CLEAR_COLOR constant; shared with pixel stages and framebuffer.
- Sub-module rr_arbiter (NUM_REQ param; inputs req vector + pointer; outputs one-hot grant + index), purely combinational; FSM, counter, pointer, output regs in top.

## Test plan
- Single requester 0 valid, addr 16'h0010, color 16'h001F, cycle T → ready[0]=1 at T; T+1 we_out=1, waddr 16'h0010, wdata 16'h001F.
- Both requesters valid continuously, 6 cycles, pointer 0 → grants 0,1,0,1,0,1; six consecutive writes, no bubbles.
- FB_DEPTH=16 (test override), clear_start at T → writes addr 0..15 data 16'h0000 at T+1..T+16, busy those cycles, done at T+16, ready 0 throughout, requester granted at T+17.
- clear_start and requester valid same cycle → no ready that cycle; pixel written only after clear completes.
- Accept addr ≥ FB_DEPTH (e.g. 60000) → ready handshakes, we_out stays 0 next cycle.
- rst_in asserted mid-clear (counter ~8) → next cycle we_out 0, busy 0, done never pulses; fresh clear_start runs full sweep from addr 0.
